// File: rtl/poly_mult_syntop.sv
// Standalone negacyclic polynomial multiplier c = a*u mod (x^N+1, 2^QW) with on-chip operands.
// Optional result read port enabled by defining POLY_MULT_RESULT_PORT_EN.
module poly_mult_syntop #(
  parameter int              N         = 16,
  parameter int              QW        = 64,
  parameter int              UW        = 1,
  parameter logic [QW-1:0]   A_SEED    = QW'(1'b1),
  parameter logic [QW-1:0]   A_STEP    = QW'(1'b1),
  parameter logic [N*UW-1:0] U_PATTERN = (N*UW)'(1'b1)
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 locked,
`ifdef POLY_MULT_RESULT_PORT_EN
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [QW-1:0]        rd_data,
`else
`endif
  output logic                 busy,
  output logic                 done,
  output logic [QW-1:0]        signature
);

  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] LAST = LW'(N - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    SIG  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_r;
  logic            sync1_r;
  logic            locked_s;
  logic [LW-1:0]   i_r;
  logic [LW-1:0]   j_r;
  logic [QW-1:0]   sig_acc_r;
  logic [QW-1:0]   a_r [N];
  logic [UW-1:0]   u_r [N];
  logic [QW-1:0]   c_r [N];

  logic            wrap_s;
  logic [LW-1:0]   k_s;
  logic [QW-1:0]   prod_s;
  logic [QW-1:0]   mac_s;
  logic [QW-1:0]   a_gen_s;

  // UW-bit by QW-bit multiply, truncated to QW bits (a mux when UW=1)
  function automatic logic [QW-1:0] mul_trunc(input logic [QW-1:0] a, input logic [UW-1:0] u);
    mul_trunc = a * QW'(u);
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1_r  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_r  <= locked;
      locked_s <= sync1_r;
    end
  end

  // MAC datapath: the carry out of i+j marks the x^N wrap, which negates the term
  always_comb begin
    {wrap_s, k_s} = {1'b0, i_r} + {1'b0, j_r};
    prod_s        = mul_trunc(a_r[i_r], u_r[j_r]);
    a_gen_s       = A_SEED + QW'(j_r) * A_STEP;
    if (wrap_s) begin
      mac_s = c_r[k_s] - prod_s;
    end else begin
      mac_s = c_r[k_s] + prod_s;
    end
  end

  // Sequencer FSM with operand/result registers and registered status outputs
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r   <= IDLE;
      i_r       <= '0;
      j_r       <= '0;
      sig_acc_r <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
      for (int n = 0; n < N; n++) begin
        a_r[n] <= '0;
        u_r[n] <= '0;
        c_r[n] <= '0;
      end
    end else begin
      busy      <= locked_s && (state_r == LOAD || state_r == MAC || state_r == SIG);
      done      <= locked_s && (state_r == DONE);
      signature <= (locked_s && state_r == DONE) ? sig_acc_r : '0;
      if (!locked_s) begin
        state_r   <= IDLE;
        i_r       <= '0;
        j_r       <= '0;
        sig_acc_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            i_r       <= '0;
            j_r       <= '0;
            sig_acc_r <= '0;
            state_r   <= LOAD;
          end
          LOAD: begin
            a_r[j_r] <= a_gen_s;
            u_r[j_r] <= U_PATTERN[int'(j_r)*UW +: UW];
            c_r[j_r] <= '0;
            j_r      <= j_r + LW'(1'b1);
            if (j_r == LAST) begin
              state_r <= MAC;
            end else begin
              state_r <= LOAD;
            end
          end
          MAC: begin
            c_r[k_s] <= mac_s;
            j_r      <= j_r + LW'(1'b1);
            if (j_r == LAST) begin
              i_r <= i_r + LW'(1'b1);
            end else begin
              i_r <= i_r;
            end
            if (j_r == LAST && i_r == LAST) begin
              state_r <= SIG;
            end else begin
              state_r <= MAC;
            end
          end
          SIG: begin
            sig_acc_r <= sig_acc_r + c_r[j_r];
            j_r       <= j_r + LW'(1'b1);
            if (j_r == LAST) begin
              state_r <= DONE;
            end else begin
              state_r <= SIG;
            end
          end
          DONE: begin
            state_r <= DONE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef POLY_MULT_RESULT_PORT_EN
  // Result read port, forced to zero whenever the product is not complete
  always_comb begin
    if (done) begin
      rd_data = c_r[rd_addr];
    end else begin
      rd_data = '0;
    end
  end
`else
`endif

endmodule

// File: tb/tb_poly_mult_syntop.sv
// Scoreboarded bench for poly_mult_syntop: four operand configurations share clock, reset and lock.
module tb_poly_mult_syntop;
  localparam int QW = 64;

  logic clk = 1'b0;
  logic arstn;
  logic locked;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;
  logic [QW-1:0] sig0, sig1, sig2, sig3;
  logic [QW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
`ifdef POLY_MULT_RESULT_PORT_EN
  logic [3:0] rd_addr = 4'd0;
  logic [QW-1:0] rd0, rd1, rd2, rd3;
`endif

  always #5 clk = ~clk;

  poly_mult_syntop u_def (
    .clk(clk), .arstn(arstn), .locked(locked),
`ifdef POLY_MULT_RESULT_PORT_EN
    .rd_addr(rd_addr), .rd_data(rd0),
`endif
    .busy(busy0), .done(done0), .signature(sig0));

  poly_mult_syntop #(.U_PATTERN(16'd2)) u_x (
    .clk(clk), .arstn(arstn), .locked(locked),
`ifdef POLY_MULT_RESULT_PORT_EN
    .rd_addr(rd_addr), .rd_data(rd1),
`endif
    .busy(busy1), .done(done1), .signature(sig1));

  poly_mult_syntop #(.U_PATTERN(16'd0)) u_zero (
    .clk(clk), .arstn(arstn), .locked(locked),
`ifdef POLY_MULT_RESULT_PORT_EN
    .rd_addr(rd_addr), .rd_data(rd2),
`endif
    .busy(busy2), .done(done2), .signature(sig2));

  poly_mult_syntop #(.A_SEED(64'hFFFF_FFFF_FFFF_FFFF)) u_wrap (
    .clk(clk), .arstn(arstn), .locked(locked),
`ifdef POLY_MULT_RESULT_PORT_EN
    .rd_addr(rd_addr), .rd_data(rd3),
`endif
    .busy(busy3), .done(done3), .signature(sig3));

  task automatic check_val(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected signatures, one per instance, in instance order.
  // u=1: sum 1..16 = 136. u=x: (1+..+15) - 16 = 104. u=0: 0.
  // a_i = -1 + i, u=1: -1 + (0+..+14) = 104.
  task automatic push_exp();
    exp_q.push_back(64'd136);
    exp_q.push_back(64'd104);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd104);
  endtask

  // Called between a negedge and the next posedge, just after lock is presented (that posedge is edge 0)
  task automatic run_and_check(input string tag);
    int busy_cnt = 0;
    int rise = -1;
    @(posedge clk);
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (busy0) busy_cnt++;
      if (done0 || done1 || done2 || done3) begin
        rise = n;
        break;
      end
    end
    check_val({tag, "_rise"}, QW'(rise), 64'd291);
    check_val({tag, "_busy_cycles"}, QW'(busy_cnt), 64'd288);
    check_val({tag, "_done_all"}, {60'd0, done3, done2, done1, done0}, 64'hF);
    check_val({tag, "_busy_low"}, {60'd0, busy3, busy2, busy1, busy0}, 64'h0);
    if (exp_q.size() < 4) begin
      check_val({tag, "_scoreboard_empty"}, QW'(exp_q.size()), 64'd4);
    end else begin
      check_val({tag, "_sig_def"}, sig0, exp_q.pop_front());
      check_val({tag, "_sig_x"}, sig1, exp_q.pop_front());
      check_val({tag, "_sig_zero"}, sig2, exp_q.pop_front());
      check_val({tag, "_sig_wrap"}, sig3, exp_q.pop_front());
    end
`ifdef POLY_MULT_RESULT_PORT_EN
    rd_addr = 4'd0;
    #1;
    check_val({tag, "_rd_x_c0"}, rd1, 64'hFFFF_FFFF_FFFF_FFF0);
    check_val({tag, "_rd_wrap_c0"}, rd3, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr = 4'd5;
    #1;
    check_val({tag, "_rd_def_c5"}, rd0, 64'd6);
    check_val({tag, "_rd_x_c5"}, rd1, 64'd5);
`endif
  endtask

  task automatic drop_lock(input string tag);
    @(negedge clk);
    locked = 1'b0;
    repeat (5) @(negedge clk);
    check_val({tag, "_busy0"}, {63'd0, busy0}, 64'd0);
    check_val({tag, "_done0"}, {63'd0, done0}, 64'd0);
    check_val({tag, "_sig0"}, sig0, 64'd0);
`ifdef POLY_MULT_RESULT_PORT_EN
    check_val({tag, "_rd0_idle"}, rd0, 64'd0);
`endif
  endtask

  initial begin
    arstn  = 1'b0;
    locked = 1'b0;
    #2;
    check_val("rst_busy", {63'd0, busy0}, 64'd0);
    check_val("rst_done", {63'd0, done0}, 64'd0);
    check_val("rst_sig", sig0, 64'd0);
    #1 arstn = 1'b1;
    repeat (2) @(negedge clk);
    check_val("pre_lock_busy", {63'd0, busy0}, 64'd0);
    check_val("pre_lock_done", {63'd0, done0}, 64'd0);

    // Uninterrupted first run
    locked = 1'b1;
    push_exp();
    run_and_check("run1");

    // Loss of lock from DONE, then relock and lose it again mid-MAC
    drop_lock("drop_done");
    locked = 1'b1;
    push_exp();
    repeat (50) @(negedge clk);
    check_val("mid_mac_busy", {63'd0, busy0}, 64'd1);
    check_val("mid_mac_done", {63'd0, done0}, 64'd0);
    drop_lock("drop_mac");
    // The aborted run never completes: discard its expectations
    repeat (4) void'(exp_q.pop_front());
    locked = 1'b1;
    push_exp();
    run_and_check("relock");

    // Asynchronous reset while done is high
    @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    check_val("arst_busy", {63'd0, busy0}, 64'd0);
    check_val("arst_done", {63'd0, done0}, 64'd0);
    check_val("arst_sig", sig0, 64'd0);
    check_val("arst_sig_x", sig1, 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    push_exp();
    run_and_check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
